// File: rtl/pmp_csr_file.sv
// rtl/pmp_csr_file.sv - M-mode PMP CSR storage (pmpcfg0-3, pmpaddr0-15) with L/WARL/TOR-lock rules
module pmp_csr_file #(
   parameter int         PMP_CNT = 16,
   parameter int         VLEN    = 31,
   parameter logic [1:0] A1_TOR  = 2'b01,
   parameter logic [1:0] M_MODE  = 2'b11
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [1:0]                io_prv,
   input  logic                      io_csr_req,
   input  logic                      io_csr_we,
   input  logic [11:0]               io_csr_addr,
   input  logic [31:0]               io_csr_wdata,
   output logic                      io_csr_ready,
   output logic                      io_csr_ack,
   output logic [31:0]               io_csr_rdata,
   output logic                      io_csr_illegal,
   output logic                      io_cfg_update,
   output logic [PMP_CNT*8-1:0]      io_pmpcfg,
   output logic [PMP_CNT*(VLEN+1)-1:0] io_pmpaddr
);

   typedef enum logic {S_IDLE, S_RESP} state_t;

   state_t        r_state;
   logic [7:0]    r_cfg  [PMP_CNT];
   logic [VLEN:0] r_addr [PMP_CNT];
   logic          r_ready;
   logic          r_ack;
   logic          r_illegal;
   logic          r_update;
   logic [31:0]   r_rdata;

   logic [7:0]    w_cfg_nxt  [PMP_CNT];
   logic [VLEN:0] w_addr_nxt [PMP_CNT];
   logic [PMP_CNT-1:0] w_addr_lock;
   logic          w_is_cfg;
   logic          w_is_addr;
   logic          w_legal;
   logic          w_accept;
   logic          w_cfg_wr;
   logic          w_addr_wr;
   logic          w_changed;
   logic [1:0]    w_cfg_idx;
   logic [3:0]    w_addr_idx;
   logic [31:0]   w_rdata;

   // Stored cfg byte: reserved bits cleared, W kept only when R is also set.
   function automatic logic [7:0] f_warl(input logic [7:0] b);
      return {b[7], 2'b00, b[4:3], b[2], b[1] & b[0], b[0]};
   endfunction

   assign w_is_cfg   = (io_csr_addr[11:4] == 8'h3A) && (io_csr_addr[3:2] == 2'b00);
   assign w_is_addr  = (io_csr_addr[11:4] == 8'h3B);
   assign w_legal    = (io_prv == M_MODE) && (w_is_cfg || w_is_addr);
   assign w_cfg_idx  = io_csr_addr[1:0];
   assign w_addr_idx = io_csr_addr[3:0];
   assign w_accept   = (r_state == S_IDLE) && io_csr_req;
   assign w_cfg_wr   = w_accept && io_csr_we && w_legal && w_is_cfg;
   assign w_addr_wr  = w_accept && io_csr_we && w_legal && w_is_addr;

   for (genvar i = 0; i < PMP_CNT; i++) begin : g_entry
      // An address is also frozen when it serves as the base of a locked TOR entry above it.
      if (i < PMP_CNT - 1) begin : g_tor
         assign w_addr_lock[i] = r_cfg[i][7] | (r_cfg[i+1][7] & (r_cfg[i+1][4:3] == A1_TOR));
      end else begin : g_last
         assign w_addr_lock[i] = r_cfg[i][7];
      end
      assign io_pmpcfg[8*i +: 8]             = r_cfg[i];
      assign io_pmpaddr[(VLEN+1)*i +: VLEN+1] = r_addr[i];
   end

   always_comb begin
      for (int e = 0; e < PMP_CNT; e++) begin
         w_cfg_nxt[e]  = r_cfg[e];
         w_addr_nxt[e] = r_addr[e];
         if (w_cfg_wr && (e[3:2] == w_cfg_idx) && !r_cfg[e][7])
            w_cfg_nxt[e] = f_warl(io_csr_wdata[8*(e%4) +: 8]);
         if (w_addr_wr && (e[3:0] == w_addr_idx) && !w_addr_lock[e])
            w_addr_nxt[e] = io_csr_wdata[VLEN:0];
      end
   end

   always_comb begin
      w_changed = 1'b0;
      for (int e = 0; e < PMP_CNT; e++)
         w_changed = w_changed | (w_cfg_nxt[e] != r_cfg[e]) | (w_addr_nxt[e] != r_addr[e]);
   end

   always_comb begin
      w_rdata = 32'h0;
      if (w_legal && !io_csr_we) begin
         if (w_is_cfg)
            w_rdata = {r_cfg[{w_cfg_idx, 2'd3}], r_cfg[{w_cfg_idx, 2'd2}],
                       r_cfg[{w_cfg_idx, 2'd1}], r_cfg[{w_cfg_idx, 2'd0}]};
         else
            w_rdata = r_addr[w_addr_idx];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b1;
         r_ack     <= 1'b0;
         r_illegal <= 1'b0;
         r_update  <= 1'b0;
         r_rdata   <= 32'h0;
         for (int e = 0; e < PMP_CNT; e++) begin
            r_cfg[e]  <= 8'h0;
            r_addr[e] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io_csr_req) begin
                  r_state   <= S_RESP;
                  r_ready   <= 1'b0;
                  r_ack     <= 1'b1;
                  r_illegal <= !w_legal;
                  r_update  <= w_changed;
                  r_rdata   <= w_rdata;
                  for (int e = 0; e < PMP_CNT; e++) begin
                     r_cfg[e]  <= w_cfg_nxt[e];
                     r_addr[e] <= w_addr_nxt[e];
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_ready   <= 1'b1;
               r_ack     <= 1'b0;
               r_illegal <= 1'b0;
               r_update  <= 1'b0;
               r_rdata   <= 32'h0;
            end
         endcase
      end
   end

   assign io_csr_ready   = r_ready;
   assign io_csr_ack     = r_ack;
   assign io_csr_illegal = r_illegal;
   assign io_cfg_update  = r_update;
   assign io_csr_rdata   = r_rdata;

endmodule

// File: tb/tb_pmp_csr_file.sv
// tb/tb_pmp_csr_file.sv - directed + randomized bench for pmp_csr_file against a behavioural model
module tb_pmp_csr_file;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic [1:0]   io_prv = 2'b11;
   logic         io_csr_req = 1'b0;
   logic         io_csr_we = 1'b0;
   logic [11:0]  io_csr_addr = 12'h0;
   logic [31:0]  io_csr_wdata = 32'h0;
   logic         io_csr_ready;
   logic         io_csr_ack;
   logic [31:0]  io_csr_rdata;
   logic         io_csr_illegal;
   logic         io_cfg_update;
   logic [127:0] io_pmpcfg;
   logic [511:0] io_pmpaddr;

   pmp_csr_file dut (
      .clock(clock), .reset_n(reset_n), .io_prv(io_prv),
      .io_csr_req(io_csr_req), .io_csr_we(io_csr_we), .io_csr_addr(io_csr_addr),
      .io_csr_wdata(io_csr_wdata), .io_csr_ready(io_csr_ready), .io_csr_ack(io_csr_ack),
      .io_csr_rdata(io_csr_rdata), .io_csr_illegal(io_csr_illegal),
      .io_cfg_update(io_cfg_update), .io_pmpcfg(io_pmpcfg), .io_pmpaddr(io_pmpaddr)
   );

   always #5 clock = ~clock;

   int n_pass = 0;
   int n_total = 0;
   logic [7:0]  m_cfg  [16];
   logic [31:0] m_addr [16];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_cfg[i] = 8'h0;
         m_addr[i] = 32'h0;
      end
   endtask

   // Applies one access to the model and returns what the block should report.
   task automatic model_access(input logic we, input logic [11:0] a, input logic [31:0] d,
                               input logic [1:0] prv, output logic ill, output logic [31:0] rd,
                               output logic upd);
      logic [7:0] old_cfg [16];
      logic [7:0] b;
      int k;
      int idx;
      logic locked;
      ill = 1'b1; rd = 32'h0; upd = 1'b0;
      for (int i = 0; i < 16; i++) old_cfg[i] = m_cfg[i];
      if (prv != 2'b11) return;
      if (a >= 12'h3A0 && a <= 12'h3A3) begin
         ill = 1'b0;
         k = int'(a) - 'h3A0;
         if (!we) begin
            rd = {m_cfg[4*k+3], m_cfg[4*k+2], m_cfg[4*k+1], m_cfg[4*k]};
         end else begin
            for (int j = 0; j < 4; j++) begin
               b = d[8*j +: 8];
               if (!old_cfg[4*k+j][7]) begin
                  b = b & 8'h9F;
                  if (b[1] && !b[0]) b[1] = 1'b0;
                  if (b != m_cfg[4*k+j]) upd = 1'b1;
                  m_cfg[4*k+j] = b;
               end
            end
         end
      end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
         ill = 1'b0;
         idx = int'(a) - 'h3B0;
         if (!we) begin
            rd = m_addr[idx];
         end else begin
            locked = old_cfg[idx][7];
            if (idx < 15 && old_cfg[idx+1][7] && old_cfg[idx+1][4:3] == 2'b01) locked = 1'b1;
            if (!locked) begin
               if (m_addr[idx] != d) upd = 1'b1;
               m_addr[idx] = d;
            end
         end
      end
   endtask

   task automatic check_state(input string tag);
      logic [127:0] ec;
      logic [511:0] ea;
      for (int i = 0; i < 16; i++) begin
         ec[8*i +: 8]  = m_cfg[i];
         ea[32*i +: 32] = m_addr[i];
      end
      chk({tag, ".pmpcfg"}, {384'h0, io_pmpcfg}, {384'h0, ec});
      chk({tag, ".pmpaddr"}, io_pmpaddr, ea);
   endtask

   task automatic csr(input string tag, input logic we, input logic [11:0] a,
                      input logic [31:0] d, input logic [1:0] prv);
      logic ill;
      logic [31:0] rd;
      logic upd;
      int waited;
      @(negedge clock);
      waited = 0;
      while (!io_csr_ready && waited < 4) begin
         @(negedge clock);
         waited++;
      end
      chk({tag, ".ready_before"}, {511'h0, io_csr_ready}, 512'h1);
      io_csr_req = 1'b1; io_csr_we = we; io_csr_addr = a; io_csr_wdata = d; io_prv = prv;
      model_access(we, a, d, prv, ill, rd, upd);
      @(posedge clock);
      #1;
      io_csr_req = 1'b0;
      chk({tag, ".ack"}, {511'h0, io_csr_ack}, 512'h1);
      chk({tag, ".ready_low"}, {511'h0, io_csr_ready}, 512'h0);
      chk({tag, ".illegal"}, {511'h0, io_csr_illegal}, {511'h0, ill});
      chk({tag, ".update"}, {511'h0, io_cfg_update}, {511'h0, upd});
      if (!we || ill) chk({tag, ".rdata"}, {480'h0, io_csr_rdata}, {480'h0, rd});
      check_state(tag);
      @(posedge clock);
      #1;
      chk({tag, ".ack_done"}, {511'h0, io_csr_ack}, 512'h0);
      chk({tag, ".ready_back"}, {511'h0, io_csr_ready}, 512'h1);
      chk({tag, ".rdata_idle"}, {480'h0, io_csr_rdata}, 512'h0);
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] d;
      logic [11:0] a;
      logic [1:0]  prv;
      model_reset();
      #12;
      chk("reset.ready", {511'h0, io_csr_ready}, 512'h1);
      chk("reset.ack", {511'h0, io_csr_ack}, 512'h0);
      chk("reset.illegal", {511'h0, io_csr_illegal}, 512'h0);
      chk("reset.update", {511'h0, io_cfg_update}, 512'h0);
      check_state("reset");
      reset_n = 1'b1;

      csr("rd_cfg0", 1'b0, 12'h3A0, 32'h0, 2'b11);
      csr("rd_addr5", 1'b0, 12'h3B5, 32'h0, 2'b11);
      csr("wr_cfg0", 1'b1, 12'h3A0, 32'h0000_1F9F, 2'b11);
      csr("rb_cfg0", 1'b0, 12'h3A0, 32'h0, 2'b11);
      csr("wr_cfg1_rsv", 1'b1, 12'h3A1, 32'h0000_0002, 2'b11);
      csr("wr_cfg0_locked", 1'b1, 12'h3A0, 32'h0, 2'b11);
      csr("wr_addr0_locked", 1'b1, 12'h3B0, 32'h0000_DEAD, 2'b11);
      csr("wr_cfg_tor", 1'b1, 12'h3A0, 32'h0000_8800, 2'b11);
      csr("wr_addr0_tor", 1'b1, 12'h3B0, 32'h0000_1234, 2'b11);
      csr("wr_addr1_locked", 1'b1, 12'h3B1, 32'h0000_1234, 2'b11);
      csr("wr_addr3", 1'b1, 12'h3B3, 32'hCAFE_F00D, 2'b11);
      csr("wr_addr3_same", 1'b1, 12'h3B3, 32'hCAFE_F00D, 2'b11);
      csr("wr_addr2_smode", 1'b1, 12'h3B2, 32'h5, 2'b01);
      csr("rd_3a7", 1'b0, 12'h3A7, 32'h0, 2'b11);
      csr("rd_addr3", 1'b0, 12'h3B3, 32'h0, 2'b11);

      for (int n = 0; n < 300; n++) begin
         r = $urandom;
         d = $urandom;
         case (r[2:0])
            3'd0, 3'd1: a = 12'h3A0 + {10'h0, r[4:3]};
            3'd2, 3'd3, 3'd4: a = 12'h3B0 + {8'h0, r[8:5]};
            3'd5: a = 12'h3A4 + 12'($urandom_range(0, 11));
            default: a = 12'($urandom);
         endcase
         if (a[11:4] == 8'h3A && r[10:9] != 2'b00) d = d & 32'h7F7F7F7F;
         prv = (r[13:11] == 3'd0) ? 2'($urandom_range(0, 2)) : 2'b11;
         csr("rand", r[14], a, d, prv);
      end

      @(negedge clock);
      io_csr_req = 1'b1; io_csr_we = 1'b1; io_csr_addr = 12'h3B6; io_csr_wdata = 32'h1111_2222;
      io_prv = 2'b11;
      @(posedge clock);
      #1;
      io_csr_req = 1'b0;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("midreset.ack", {511'h0, io_csr_ack}, 512'h0);
      chk("midreset.ready", {511'h0, io_csr_ready}, 512'h1);
      check_state("midreset");
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk("postreset.ack", {511'h0, io_csr_ack}, 512'h0);
      chk("postreset.ready", {511'h0, io_csr_ready}, 512'h1);
      csr("postreset.rd_addr6", 1'b0, 12'h3B6, 32'h0, 2'b11);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
